// File: rtl/fib_seq_pkg.sv
// Shared definitions for the sequence engine: FSM states, mode encodings,
// seed constants and flag bit positions.
package fib_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEED0,
    ST_SEED1,
    ST_STEP,
    ST_DONE
  } state_t;

  localparam logic [1:0] MODE_FIB   = 2'd0;
  localparam logic [1:0] MODE_LUCAS = 2'd1;
  localparam logic [1:0] MODE_STEP  = 2'd2;

  localparam int unsigned FIB_SEED_A   = 0;
  localparam int unsigned FIB_SEED_B   = 1;
  localparam int unsigned LUCAS_SEED_A = 2;
  localparam int unsigned LUCAS_SEED_B = 1;

  localparam int unsigned FLAG_C = 4;
  localparam int unsigned FLAG_L = 3;
  localparam int unsigned FLAG_F = 2;
  localparam int unsigned FLAG_Z = 1;
  localparam int unsigned FLAG_N = 0;

endpackage

// File: rtl/fib_seq_adder.sv
// Shared WIDTH-bit adder producing the sum and {C, L, F, Z, N} flags.
module fib_seq_adder
  import fib_seq_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sum,
  output logic [4:0]       flags
);

  logic [WIDTH:0] full;

  always_comb begin
    full          = {1'b0, a} + {1'b0, b};
    sum           = full[WIDTH-1:0];
    flags         = '0;
    flags[FLAG_C] = full[WIDTH];
    flags[FLAG_L] = (a < b);
    flags[FLAG_F] = (a[WIDTH-1] == b[WIDTH-1]) && (full[WIDTH-1] != a[WIDTH-1]);
    flags[FLAG_Z] = (full[WIDTH-1:0] == '0);
    flags[FLAG_N] = full[WIDTH-1];
  end

endmodule

// File: rtl/hexTo7Seg.sv
// Hex nibble to seven-segment decoder, segments {g,f,e,d,c,b,a}, active-low.
module hexTo7Seg (
  input  logic [3:0] hex,
  output logic [6:0] seg
);

  always_comb begin
    seg = 7'h7F;
    case (hex)
      4'h0: seg = 7'h40;
      4'h1: seg = 7'h79;
      4'h2: seg = 7'h24;
      4'h3: seg = 7'h30;
      4'h4: seg = 7'h19;
      4'h5: seg = 7'h12;
      4'h6: seg = 7'h02;
      4'h7: seg = 7'h78;
      4'h8: seg = 7'h00;
      4'h9: seg = 7'h10;
      4'hA: seg = 7'h08;
      4'hB: seg = 7'h03;
      4'hC: seg = 7'h46;
      4'hD: seg = 7'h21;
      4'hE: seg = 7'h06;
      4'hF: seg = 7'h0E;
      default: seg = 7'h7F;
    endcase
  end

endmodule

// File: rtl/fib_seq_engine.sv
// Fibonacci / Lucas / constant-step sequence engine with circular register
// file, start/busy/done handshake and hex seven-segment output.
module fib_seq_engine
  import fib_seq_pkg::*;
#(
  parameter int unsigned WIDTH    = 16,
  parameter int unsigned NUM_REGS = 16,
  parameter int unsigned CNT_W    = 8,
  parameter int unsigned DIGITS   = WIDTH / 4,
  localparam int unsigned AW      = $clog2(NUM_REGS)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [1:0]            mode,
  input  logic [CNT_W-1:0]      count,
  input  logic [WIDTH-1:0]      base,
  input  logic [WIDTH-1:0]      step,
  input  logic                  halt_on_carry,
  output logic                  busy,
  output logic                  done,
  output logic                  ovf,
  output logic [CNT_W-1:0]      terms,
  output logic [WIDTH-1:0]      bus,
  output logic [4:0]            flags,
  input  logic [AW-1:0]         rd_addr,
  output logic [WIDTH-1:0]      rd_data,
  output logic [7*DIGITS-1:0]   seven_seg
);

  state_t state, state_next;

  logic [1:0]       mode_q;
  logic [CNT_W-1:0] count_q;
  logic [WIDTH-1:0] base_q, step_q;
  logic             hoc_q;
  logic [WIDTH-1:0] prev1, prev2;
  logic [AW-1:0]    wp;
  logic [WIDTH-1:0] mem [NUM_REGS];

  logic             is_step, is_lucas;
  logic [WIDTH-1:0] add_a, add_b, add_sum;
  logic [4:0]       add_flags;
  logic             add_use, halt, wr_en;
  logic [WIDTH-1:0] wr_data;

  assign is_step  = (mode_q == MODE_STEP);
  assign is_lucas = (mode_q == MODE_LUCAS);

  fib_seq_adder #(.WIDTH(WIDTH)) u_adder (
    .a     (add_a),
    .b     (add_b),
    .sum   (add_sum),
    .flags (add_flags)
  );

  // The adder is shared: SEED1 forms base+step, STEP forms the next term.
  always_comb begin
    add_a   = prev1;
    add_b   = is_step ? step_q : prev2;
    add_use = 1'b0;
    wr_en   = 1'b0;
    wr_data = '0;
    halt    = 1'b0;
    case (state)
      ST_SEED0: begin
        wr_en   = 1'b1;
        wr_data = is_step  ? base_q :
                  is_lucas ? WIDTH'(LUCAS_SEED_A) : WIDTH'(FIB_SEED_A);
      end
      ST_SEED1: begin
        add_a   = base_q;
        add_b   = step_q;
        add_use = is_step;
        wr_en   = 1'b1;
        wr_data = is_step  ? add_sum :
                  is_lucas ? WIDTH'(LUCAS_SEED_B) : WIDTH'(FIB_SEED_B);
      end
      ST_STEP: begin
        add_use = 1'b1;
        halt    = hoc_q && add_flags[FLAG_C];
        wr_en   = !halt;
        wr_data = add_sum;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:  if (start) state_next = (count == '0) ? ST_DONE : ST_SEED0;
      ST_SEED0: state_next = (count_q == CNT_W'(1)) ? ST_DONE : ST_SEED1;
      ST_SEED1: state_next = (count_q == CNT_W'(2)) ? ST_DONE : ST_STEP;
      ST_STEP:  if (halt || (terms + 1'b1 == count_q)) state_next = ST_DONE;
      ST_DONE:  state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mode_q  <= '0;
      count_q <= '0;
      base_q  <= '0;
      step_q  <= '0;
      hoc_q   <= 1'b0;
      prev1   <= '0;
      prev2   <= '0;
      wp      <= '0;
      terms   <= '0;
      bus     <= '0;
      flags   <= '0;
      ovf     <= 1'b0;
      for (int unsigned i = 0; i < NUM_REGS; i++) mem[i] <= '0;
    end else begin
      if (state == ST_IDLE && start) begin
        mode_q  <= mode;
        count_q <= count;
        base_q  <= base;
        step_q  <= step;
        hoc_q   <= halt_on_carry;
        terms   <= '0;
        ovf     <= 1'b0;
        wp      <= '0;
      end
      if (wr_en) begin
        mem[wp] <= wr_data;
        bus     <= wr_data;
        wp      <= wp + 1'b1;
        terms   <= terms + 1'b1;
        prev2   <= prev1;
        prev1   <= wr_data;
      end
      if (add_use) flags <= add_flags;
      if (halt)    ovf   <= 1'b1;
    end
  end

  assign busy    = (state != ST_IDLE);
  assign done    = (state == ST_DONE);
  assign rd_data = mem[rd_addr];

  for (genvar i = 0; i < DIGITS; i++) begin : g_digit
    hexTo7Seg u_hex (
      .hex (bus[4*i +: 4]),
      .seg (seven_seg[7*i +: 7])
    );
  end

endmodule

// File: tb/tb_fib_seq_engine.sv
// Self-checking bench for fib_seq_engine: spec vectors, control corner cases
// and randomized runs against a term-list reference model.
module tb_fib_seq_engine;

  localparam int W  = 16;
  localparam int NR = 16;
  localparam int CW = 8;
  localparam int DG = 4;

  logic          clk = 1'b0;
  logic          reset, start, halt_on_carry;
  logic [1:0]    mode;
  logic [CW-1:0] count;
  logic [W-1:0]  base, step;
  logic          busy, done, ovf;
  logic [CW-1:0] terms;
  logic [W-1:0]  bus, rd_data;
  logic [4:0]    flags;
  logic [3:0]    rd_addr;
  logic [7*DG-1:0] seven_seg;

  fib_seq_engine #(.WIDTH(W), .NUM_REGS(NR), .CNT_W(CW), .DIGITS(DG)) dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .mode          (mode),
    .count         (count),
    .base          (base),
    .step          (step),
    .halt_on_carry (halt_on_carry),
    .busy          (busy),
    .done          (done),
    .ovf           (ovf),
    .terms         (terms),
    .bus           (bus),
    .flags         (flags),
    .rd_addr       (rd_addr),
    .rd_data       (rd_data),
    .seven_seg     (seven_seg)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model state
  logic [W-1:0] m_mem [NR];
  logic [W-1:0] m_bus;
  logic [4:0]   m_flags;
  logic         m_ovf;
  int           m_terms;

  function automatic logic [7*DG-1:0] seg_exp(input logic [W-1:0] v);
    logic [6:0] t [16];
    logic [7*DG-1:0] r;
    t = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
          7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    r = '0;
    for (int d = 0; d < DG; d++) r[7*d +: 7] = t[v[4*d +: 4]];
    return r;
  endfunction

  task automatic m_add(input logic [W-1:0] a, input logic [W-1:0] b,
                       output logic [W-1:0] s, output logic c);
    int unsigned full;
    shortint sa, sb;
    int ssum;
    full = int'(a) + int'(b);
    s    = full[W-1:0];
    c    = (full > 32'hFFFF);
    sa   = a;
    sb   = b;
    ssum = int'(sa) + int'(sb);
    m_flags = {c, (a < b), (ssum > 32767 || ssum < -32768), (s == 0), s[W-1]};
  endtask

  task automatic model_run(input logic [1:0] md, input int cnt, input logic [W-1:0] bs,
                           input logic [W-1:0] st, input logic hoc, output int done_cyc);
    logic [W-1:0] seq [$];
    logic [W-1:0] v;
    logic c;
    m_ovf = 1'b0;
    seq = {};
    done_cyc = cnt + 1;
    for (int k = 0; k < cnt; k++) begin
      if (k == 0) v = (md == 2'd1) ? 16'd2 : (md == 2'd2) ? bs : 16'd0;
      else if (k == 1) begin
        if (md == 2'd2) m_add(bs, st, v, c);
        else v = 16'd1;
      end else begin
        m_add(seq[k-1], (md == 2'd2) ? st : seq[k-2], v, c);
        if (hoc && c) begin
          m_ovf = 1'b1;
          done_cyc = k + 2;
          break;
        end
      end
      seq.push_back(v);
      m_mem[k % NR] = v;
      m_bus = v;
    end
    m_terms = seq.size();
  endtask

  task automatic check_outputs(input string tag);
    check({tag, " busy"}, busy, 1'b0);
    check({tag, " done"}, done, 1'b0);
    check({tag, " terms"}, terms, m_terms[CW-1:0]);
    check({tag, " bus"}, bus, m_bus);
    check({tag, " ovf"}, ovf, m_ovf);
    check({tag, " flags"}, flags, m_flags);
    check({tag, " seven_seg"}, seven_seg, seg_exp(m_bus));
    for (int i = 0; i < NR; i++) begin
      rd_addr = i[3:0];
      #1;
      check($sformatf("%s r[%0d]", tag, i), rd_data, m_mem[i]);
    end
    @(negedge clk);
  endtask

  // Called at a negedge with the DUT idle; returns at a negedge, DUT idle.
  task automatic do_run(input logic [1:0] md, input int cnt, input logic [W-1:0] bs,
                        input logic [W-1:0] st, input logic hoc, input logic hold,
                        input string tag);
    int exp_done, got, busy_bad;
    mode = md; count = cnt[CW-1:0]; base = bs; step = st; halt_on_carry = hoc;
    start = 1'b1;
    model_run(md, cnt, bs, st, hoc, exp_done);
    @(posedge clk);
    #1;
    if (!hold) start = 1'b0;
    mode = 2'($urandom); count = 8'($urandom); base = 16'($urandom); step = 16'($urandom);
    halt_on_carry = 1'($urandom);
    got = 0;
    busy_bad = 0;
    for (int cyc = 1; cyc <= 300; cyc++) begin
      @(negedge clk);
      if (busy !== 1'b1) busy_bad++;
      if (done === 1'b1) begin
        got = cyc;
        break;
      end
    end
    start = 1'b0;
    check({tag, " done cycle"}, got, exp_done);
    check({tag, " busy during run"}, busy_bad, 0);
    @(negedge clk);
    check_outputs(tag);
  endtask

  typedef struct {
    logic [1:0]  md;
    int          cnt;
    logic [W-1:0] bs;
    logic [W-1:0] st;
    logic        hoc;
    int          exp_terms;
    logic [W-1:0] exp_bus;
    logic        exp_ovf;
  } vec_t;

  vec_t vecs [7];

  initial begin
    #2_000_000;
    $display("FAIL global timeout");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0] = '{2'd0, 10, 16'h0, 16'h0, 1'b0, 10, 16'h0022, 1'b0};
    vecs[1] = '{2'd1, 10, 16'h0, 16'h0, 1'b0, 10, 16'h004C, 1'b0};
    vecs[2] = '{2'd2, 4,  16'd5, 16'd3, 1'b0, 4,  16'h000E, 1'b0};
    vecs[3] = '{2'd0, 30, 16'h0, 16'h0, 1'b1, 25, 16'hB520, 1'b1};
    vecs[4] = '{2'd0, 20, 16'h0, 16'h0, 1'b0, 20, 16'h1055, 1'b0};
    vecs[5] = '{2'd2, 0,  16'd9, 16'd9, 1'b0, 0,  16'h1055, 1'b0};
    vecs[6] = '{2'd3, 5,  16'h0, 16'h0, 1'b0, 5,  16'h0003, 1'b0};

    reset = 1'b1; start = 1'b0; mode = '0; count = '0; base = '0; step = '0;
    halt_on_carry = 1'b0; rd_addr = '0;
    for (int i = 0; i < NR; i++) m_mem[i] = '0;
    m_bus = '0; m_flags = '0; m_ovf = 1'b0; m_terms = 0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check_outputs("reset");
    check("reset seven_seg zeros", seven_seg, {4{7'h40}});

    for (int v = 0; v < 7; v++) begin
      do_run(vecs[v].md, vecs[v].cnt, vecs[v].bs, vecs[v].st, vecs[v].hoc, 1'b0,
             $sformatf("vec%0d", v));
      check($sformatf("vec%0d spec terms", v), terms, vecs[v].exp_terms[CW-1:0]);
      check($sformatf("vec%0d spec bus", v), bus, vecs[v].exp_bus);
      check($sformatf("vec%0d spec ovf", v), ovf, vecs[v].exp_ovf);
      if (v == 3) check("halt carry flag", flags[4], 1'b1);
      if (v == 4) begin
        rd_addr = 4'd3; #1; check("wrap r[3]", rd_data, 16'h1055);
        rd_addr = 4'd4; #1; check("wrap r[4]", rd_data, 16'h0003);
        @(negedge clk);
      end
    end

    // start held high for the whole run must not restart it
    do_run(2'd1, 7, 16'h0, 16'h0, 1'b0, 1'b1, "held start");

    // reset in cycle 5 of a count=10 run
    mode = 2'd0; count = 8'd10; halt_on_carry = 1'b0; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (5) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < NR; i++) m_mem[i] = '0;
    m_bus = '0; m_flags = '0; m_ovf = 1'b0; m_terms = 0;
    begin
      int done_seen;
      done_seen = 0;
      check_outputs("mid-run reset");
      repeat (3) begin
        if (done === 1'b1) done_seen++;
        @(negedge clk);
      end
      check("mid-run reset no done", done_seen, 0);
    end

    for (int r = 0; r < 25; r++) begin
      do_run(2'($urandom), int'($urandom_range(0, 40)), 16'($urandom), 16'($urandom),
             1'($urandom), 1'b0, $sformatf("rand%0d", r));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
